mz_pulse_sequencer: RTL and testbench
=====================================

Name: mz_pulse_sequencer

Overview:
- Programmable sequencer for the Mach-Zehnder RF pulse train: pi/2, interval, pi, interval, pi/2, with an optional start delay and multi-shot repeat.
- Replaces the fixed-time pulse generation with a triggered, reconfigurable state machine that drives the RF gate line.
- Sits between the experiment-control register block (cfg_*, trig, abort) and the RF switch driver (rf).

Parameters:
- CNT_W, 32, width of all duration fields and the internal down-counter.
- SHOT_W, 16, width of the shot-count fields.

Ports:
- clk  in  1  system clock; all timing is in clk cycles.
- rst_n  in  1  asynchronous, active-low reset.
- trig  in  1  start request, sampled each edge; level-sensitive.
- abort  in  1  synchronous abort; highest priority.
- cfg_delay  in  CNT_W  start delay D before the first pulse.
- cfg_pi2_len  in  CNT_W  pi/2 pulse length P2.
- cfg_pi_len  in  CNT_W  pi pulse length P.
- cfg_interval  in  CNT_W  free-evolution interval I.
- cfg_gap  in  CNT_W  dead time G between shots.
- cfg_shots  in  SHOT_W  number of shots N; 0 is treated as 1.
- rf  out  1  RF gate; registered.
- phase  out  3  current state encoding.
- busy  out  1  high while not IDLE.
- done  out  1  1-cycle pulse when the sequence completes.
- aborted  out  1  1-cycle pulse when an abort ends a run.
- err_cfg  out  1  sticky flag for a rejected configuration.
- shot_count  out  SHOT_W  number of completed shots in the current or last run.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; all cfg latches = 0.
  - rf, busy, done, aborted, err_cfg = 0; shot_count = 0; phase = 0.
- States and phase codes:
  - IDLE=0, DELAY=1, PI2_A=2, INT1=3, PI=4, INT2=5, PI2_B=6, GAP=7.
  - rf = 1 only in PI2_A, PI and PI2_B.
- Acceptance:
  - In IDLE with trig=1 and abort=0 at edge k, all cfg_* are latched and used for the whole run.
  - On acceptance: shot_count = 0 and err_cfg is cleared.
  - cfg_* changes after acceptance have no effect on the run.
- Config check at acceptance:
  - If P2==0 or P==0, the run is not started: state stays IDLE, err_cfg = 1 (sticky), busy stays 0.
- Timing, with cycle n meaning the cycle after edge n:
  - DELAY occupies cycles k+1..k+D.
  - PI2_A occupies the next P2 cycles, INT1 the next I, PI the next P, INT2 the next I, PI2_B the next P2.
  - Zero-length DELAY, INT1, INT2 or GAP states are skipped entirely (no 1-cycle bubble).
- Per-state counter: loaded with (length-1) on entry, decrements each cycle, exits when it reaches 0.
- End of PI2_B:
  - shot_count increments in the same edge that leaves PI2_B.
  - If completed shots < N: go to GAP for G cycles, then PI2_A. DELAY is not repeated.
  - Otherwise: go to IDLE, with done=1 for exactly the first IDLE cycle.
- Run length: busy spans D + N*(2*P2 + P + 2*I) + (N-1)*G cycles.
- Re-trigger: trig while busy is ignored and never queued. trig held high through done restarts on the first IDLE edge, which is allowed.
- Abort:
  - abort=1 at any edge while busy forces IDLE at that edge, so rf=0 in the next cycle.
  - aborted=1 for one cycle; done is not pulsed; shot_count holds its value.
  - abort in IDLE is a no-op and also blocks a same-edge trig.
- Arithmetic: all lengths are unsigned CNT_W. No overflow is possible because the counter only decrements from (len-1).
- rf must be glitch-free: driven directly from a flop.

Test Plan:
- D=10, P2=10, I=20, P=20, N=1, trig at edge 0:
  - rf=1 in cycles 11-20, 41-60 and 81-90; rf=0 otherwise.
  - phase follows 1,2,3,4,5,6.
  - done=1 in cycle 91 only; busy=1 in cycles 1-90; shot_count=1.
- D=0, P2=2, I=0, P=3, N=3, G=4:
  - rf=1 continuously in cycles 1-7 (pi/2, pi, pi/2 merge with zero intervals), low in 8-11, high in 12-18, low in 19-22, high in 23-29.
  - shot_count steps 1, 2, 3; done in cycle 30.
- cfg_pi_len=0 with trig:
  - busy stays 0, rf stays 0, err_cfg=1.
  - A following valid trig clears err_cfg and runs normally.
- abort asserted in cycle 45 of the first scenario (inside the pi pulse):
  - rf=0 from cycle 46; aborted=1 in cycle 46 only.
  - done is never asserted; shot_count=0; phase=0.
- trig pulsed again at cycle 30 of the first scenario, and cfg_pi_len changed to 5 mid-run:
  - Timing is identical to the first scenario; no second run follows.
- rst_n pulled low asynchronously mid-PI:
  - rf, busy and phase go to 0 immediately, without waiting for a clock edge.
  - After release, the block idles until the next trig.

Source files
------------

// File: rtl/mz_pulse_sequencer.sv
// Triggered Mach-Zehnder RF pulse-train sequencer:
// delay, pi/2, interval, pi, interval, pi/2, with gap and multi-shot repeat.
module mz_pulse_sequencer #(
    parameter int CNT_W  = 32,
    parameter int SHOT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_pi2_len,
    input  logic [CNT_W-1:0]  cfg_pi_len,
    input  logic [CNT_W-1:0]  cfg_interval,
    input  logic [CNT_W-1:0]  cfg_gap,
    input  logic [SHOT_W-1:0] cfg_shots,
    output logic              rf,
    output logic [2:0]        phase,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err_cfg,
    output logic [SHOT_W-1:0] shot_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_PI2_A = 3'd2,
        S_INT1  = 3'd3,
        S_PI    = 3'd4,
        S_INT2  = 3'd5,
        S_PI2_B = 3'd6,
        S_GAP   = 3'd7
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   d_q, p2_q, p_q, i_q, g_q;
    logic [SHOT_W-1:0]  n_q;

    logic [CNT_W-1:0]   eff_d, eff_p2, eff_p, eff_i, eff_g, len_n;
    logic [SHOT_W:0]    n_eff, shots_after;
    logic               accept, reject, shot_inc, done_n, aborted_n, rf_n;

    // In IDLE the live config is what the next run will use.
    assign eff_d  = (state == S_IDLE) ? cfg_delay    : d_q;
    assign eff_p2 = (state == S_IDLE) ? cfg_pi2_len  : p2_q;
    assign eff_p  = (state == S_IDLE) ? cfg_pi_len   : p_q;
    assign eff_i  = (state == S_IDLE) ? cfg_interval : i_q;
    assign eff_g  = (state == S_IDLE) ? cfg_gap      : g_q;

    assign n_eff       = (n_q == '0) ? (SHOT_W+1)'(1) : {1'b0, n_q};
    assign shots_after = {1'b0, shot_count} + (SHOT_W+1)'(1);

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        reject    = 1'b0;
        shot_inc  = 1'b0;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        if (abort) begin
            if (state != S_IDLE) begin
                state_n   = S_IDLE;
                aborted_n = 1'b1;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (trig) begin
                        if (cfg_pi2_len == '0 || cfg_pi_len == '0) begin
                            reject = 1'b1;
                        end else begin
                            accept  = 1'b1;
                            state_n = (cfg_delay != '0) ? S_DELAY : S_PI2_A;
                        end
                    end
                end
                S_DELAY: if (cnt == '0) state_n = S_PI2_A;
                S_PI2_A: if (cnt == '0) state_n = (eff_i != '0) ? S_INT1 : S_PI;
                S_INT1:  if (cnt == '0) state_n = S_PI;
                S_PI:    if (cnt == '0) state_n = (eff_i != '0) ? S_INT2 : S_PI2_B;
                S_INT2:  if (cnt == '0) state_n = S_PI2_B;
                S_PI2_B: begin
                    if (cnt == '0) begin
                        shot_inc = 1'b1;
                        if (shots_after < n_eff) begin
                            state_n = (eff_g != '0) ? S_GAP : S_PI2_A;
                        end else begin
                            state_n = S_IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                S_GAP:   if (cnt == '0) state_n = S_PI2_A;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        len_n = '0;
        case (state_n)
            S_DELAY:         len_n = eff_d;
            S_PI2_A, S_PI2_B: len_n = eff_p2;
            S_INT1, S_INT2:  len_n = eff_i;
            S_PI:            len_n = eff_p;
            S_GAP:           len_n = eff_g;
            default:         len_n = '0;
        endcase
        cnt_n = cnt;
        if (state_n == S_IDLE) begin
            cnt_n = '0;
        end else if (state_n != state) begin
            cnt_n = len_n - CNT_W'(1);
        end else if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
        end
        rf_n = (state_n == S_PI2_A) || (state_n == S_PI) ||
               (state_n == S_PI2_B);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            d_q        <= '0;
            p2_q       <= '0;
            p_q        <= '0;
            i_q        <= '0;
            g_q        <= '0;
            n_q        <= '0;
            rf         <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            err_cfg    <= 1'b0;
            shot_count <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rf      <= rf_n;
            done    <= done_n;
            aborted <= aborted_n;
            if (accept) begin
                d_q        <= cfg_delay;
                p2_q       <= cfg_pi2_len;
                p_q        <= cfg_pi_len;
                i_q        <= cfg_interval;
                g_q        <= cfg_gap;
                n_q        <= cfg_shots;
                shot_count <= '0;
                err_cfg    <= 1'b0;
            end else if (shot_inc) begin
                shot_count <= shot_count + SHOT_W'(1);
            end
            if (reject) err_cfg <= 1'b1;
        end
    end

    assign phase = state;
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_mz_pulse_sequencer.sv
// Directed bench for mz_pulse_sequencer: cycle-by-cycle checks of
// rf/busy/done/aborted/phase against hand-derived windows.
module tb_mz_pulse_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trig, abort;
    logic [31:0] cfg_delay, cfg_pi2_len, cfg_pi_len, cfg_interval, cfg_gap;
    logic [15:0] cfg_shots;
    logic        rf, busy, done, aborted, err_cfg;
    logic [2:0]  phase;
    logic [15:0] shot_count;

    int tests = 0;
    int fails = 0;

    mz_pulse_sequencer #(.CNT_W(32), .SHOT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .abort(abort),
        .cfg_delay(cfg_delay), .cfg_pi2_len(cfg_pi2_len),
        .cfg_pi_len(cfg_pi_len), .cfg_interval(cfg_interval),
        .cfg_gap(cfg_gap), .cfg_shots(cfg_shots),
        .rf(rf), .phase(phase), .busy(busy), .done(done),
        .aborted(aborted), .err_cfg(err_cfg), .shot_count(shot_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] vec();
        return {aborted, done, busy, rf, phase};
    endfunction

    function automatic logic [6:0] mk(bit ab, bit dn, bit bz, bit r,
                                      logic [2:0] ph);
        return {ab, dn, bz, r, ph};
    endfunction

    // D=10 P2=10 I=20 P=20 N=1; optional abort cycle and retrigger.
    task automatic run_s1(input int abort_at, input bit retrig);
        logic [2:0] ph;
        logic [6:0] e;
        cfg_delay = 10; cfg_pi2_len = 10; cfg_interval = 20;
        cfg_pi_len = 20; cfg_gap = 0; cfg_shots = 1;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int n = 1; n <= 95; n++) begin
            if (n <= 10)      ph = 3'd1;
            else if (n <= 20) ph = 3'd2;
            else if (n <= 40) ph = 3'd3;
            else if (n <= 60) ph = 3'd4;
            else if (n <= 80) ph = 3'd5;
            else if (n <= 90) ph = 3'd6;
            else              ph = 3'd0;
            e = mk(1'b0, n == 91, n <= 90,
                   ph == 3'd2 || ph == 3'd4 || ph == 3'd6, ph);
            if (abort_at > 0 && n > abort_at)
                e = mk(n == abort_at + 1, 1'b0, 1'b0, 1'b0, 3'd0);
            chk($sformatf("s1 a%0d r%0d c%0d", abort_at, retrig, n),
                32'(vec()), 32'(e));
            if (retrig && n == 5) cfg_pi_len = 5;
            trig  = retrig && n == 30;
            abort = (abort_at > 0 && n == abort_at);
            tick();
        end
        trig = 1'b0; abort = 1'b0;
        chk("s1 shot_count", 32'(shot_count), (abort_at > 0) ? 0 : 1);
    endtask

    initial begin
        logic [6:0] e;
        int off;
        rst_n = 1'b0; trig = 1'b0; abort = 1'b0;
        cfg_delay = 0; cfg_pi2_len = 0; cfg_pi_len = 0;
        cfg_interval = 0; cfg_gap = 0; cfg_shots = 0;
        #2;
        chk("reset vec", 32'(vec()), 32'(0));
        chk("reset err", 32'(err_cfg), 0);
        chk("reset shots", 32'(shot_count), 0);
        tick();
        rst_n = 1'b1;
        tick();

        run_s1(0, 1'b0);
        tick();

        // D=0 P2=2 I=0 P=3 N=3 G=4: zero intervals merge pulses.
        cfg_delay = 0; cfg_pi2_len = 2; cfg_interval = 0;
        cfg_pi_len = 3; cfg_gap = 4; cfg_shots = 3;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            if (n <= 29) begin
                off = (n - 1) % 11;
                e = mk(1'b0, 1'b0, 1'b1, off < 7,
                       off < 2 ? 3'd2 : off < 5 ? 3'd4 : off < 7 ? 3'd6 : 3'd7);
            end else begin
                e = mk(1'b0, n == 30, 1'b0, 1'b0, 3'd0);
            end
            chk($sformatf("s2 c%0d", n), 32'(vec()), 32'(e));
            chk($sformatf("s2 shots c%0d", n), 32'(shot_count),
                n >= 30 ? 3 : n >= 19 ? 2 : n >= 8 ? 1 : 0);
            tick();
        end

        // Rejected config then a valid short run.
        cfg_delay = 0; cfg_pi2_len = 4; cfg_pi_len = 0; cfg_shots = 1;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            chk($sformatf("rej c%0d", n), 32'(vec()), 32'(0));
            chk($sformatf("rej err c%0d", n), 32'(err_cfg), 1);
            tick();
        end
        cfg_pi2_len = 1; cfg_pi_len = 1; cfg_interval = 1; cfg_gap = 0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("ok err cleared", 32'(err_cfg), 0);
        for (int n = 1; n <= 6; n++) begin
            chk($sformatf("ok busy c%0d", n), 32'(busy), n <= 5 ? 1 : 0);
            chk($sformatf("ok done c%0d", n), 32'(done), n == 6 ? 1 : 0);
            tick();
        end

        // Abort in IDLE blocks a same-edge trig.
        cfg_pi2_len = 3; cfg_pi_len = 3;
        trig = 1'b1; abort = 1'b1;
        tick();
        trig = 1'b0; abort = 1'b0;
        chk("idle abort", 32'(vec()), 32'(0));

        run_s1(45, 1'b0);
        tick();
        run_s1(0, 1'b1);
        tick();

        // Async reset in the middle of the pi pulse.
        cfg_delay = 10; cfg_pi2_len = 10; cfg_interval = 20;
        cfg_pi_len = 20; cfg_shots = 1;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int n = 1; n < 45; n++) tick();
        chk("pre-reset vec", 32'(vec()), 32'(mk(0, 0, 1, 1, 3'd4)));
        #3 rst_n = 1'b0;
        #1;
        chk("async reset vec", 32'(vec()), 32'(0));
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        chk("post-reset idle", 32'(vec()), 32'(0));
        chk("post-reset shots", 32'(shot_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
